// File: rtl/a_b_out_axil_slave_if.sv
// rtl/a_b_out_axil_slave_if.sv - AXI4-Lite bundle between the A_B_OUT register bank and its master
//
// Purpose: groups the five AXI4-Lite channels (AW, W, B, AR, R) into one
// connection so the register bank and its bus master share a single port.
// Ports (signals):
//   AW: S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_AWREADY
//   W : S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_WREADY
//   B : S_AXI_BRESP, S_AXI_BVALID, S_AXI_BREADY
//   AR: S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_ARREADY
//   R : S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, S_AXI_RREADY
// Modports: slave (register bank side), master (bus master side).
interface a_b_out_axil_slave_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/a_b_out_axil_slave.sv
// rtl/a_b_out_axil_slave.sv - AXI4-Lite register bank driving A_OUT/B_OUT with an update strobe
//
// Purpose: four 32-bit read/write registers at byte offsets 0x0/0x4/0x8/0xC.
// Registers 0 and 1 are exported as A_OUT and B_OUT; AB_UPD pulses for one
// cycle, in the same cycle the outputs change, after a write to either.
// Ports:
//   ACLK    - clock, rising edge
//   ARESET  - synchronous active-high reset
//   s_axi   - AXI4-Lite slave channels (a_b_out_axil_slave_if.slave)
//   A_OUT   - copy of register 0
//   B_OUT   - copy of register 1
//   AB_UPD  - one-cycle pulse after a committed write to register 0 or 1
// Optional feature macro: A_B_OUT_SLVERR_EN. When defined, addresses with any
// bit set above bit 3 get SLVERR (writes dropped, reads return 32'hDEADBEEF).
// When undefined, upper address bits are ignored and registers alias.
module a_b_out_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_RESET_VAL = '0
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  a_b_out_axil_slave_if.slave           s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] A_OUT,
  output logic [C_S_AXI_DATA_WIDTH-1:0] B_OUT,
  output logic                          AB_UPD
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_RESP = 1'b1;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [DW-1:0] OOR_RDATA = 32'hDEAD_BEEF;

`ifdef A_B_OUT_SLVERR_EN
  // Any set bit above the 16-byte register window marks the access out of range.
  function automatic logic addr_oor(input logic [AW-1:0] a);
    logic r;
    r = 1'b0;
    for (int i = 4; i < AW; i++) r = r | a[i];
    return r;
  endfunction
`else
  // Upper bits alias onto the four registers; nothing is ever out of range.
  function automatic logic addr_oor(input logic [AW-1:0] a);
    return 1'b0 & (^a);
  endfunction
`endif

  // Register file
  logic [3:0][DW-1:0] regs_q, regs_d;

  // Write side state
  logic [0:0]      wr_state_q, wr_state_d;
  logic            aw_full_q, aw_full_d;
  logic [AW-1:0]   aw_addr_q, aw_addr_d;
  logic            w_full_q, w_full_d;
  logic [DW-1:0]   w_data_q, w_data_d;
  logic [3:0]      w_strb_q, w_strb_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            ab_upd_q, ab_upd_d;

  // Read side state
  logic [0:0]      rd_state_q, rd_state_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  // Write-side intermediates
  logic            aw_hs, w_hs;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [3:0]      wr_strb;
  logic [1:0]      wr_idx;
  logic            wr_oor;

  // Read-side intermediates
  logic            ar_hs;
  logic [1:0]      rd_idx;
  logic            rd_oor;

  // Write FSM. AW and W latch independently; the commit uses whichever copy
  // is newest (the latched one, or the bus value if it handshakes this cycle),
  // so a same-cycle AW+W handshake commits without an extra cycle.
  always_comb begin
    regs_d     = regs_q;
    wr_state_d = wr_state_q;
    aw_full_d  = aw_full_q;
    aw_addr_d  = aw_addr_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    ab_upd_d   = 1'b0;
    aw_hs      = s_axi.S_AXI_AWVALID & awready_q;
    w_hs       = s_axi.S_AXI_WVALID & wready_q;
    wr_addr    = aw_addr_q;
    wr_data    = w_data_q;
    wr_strb    = w_strb_q;
    wr_idx     = 2'd0;
    wr_oor     = 1'b0;

    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_full_d = 1'b1;
          aw_addr_d = s_axi.S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_full_d = 1'b1;
          w_data_d = s_axi.S_AXI_WDATA;
          w_strb_d = s_axi.S_AXI_WSTRB;
        end
        if (aw_full_d && w_full_d) begin
          wr_addr = aw_addr_d;
          wr_data = w_data_d;
          wr_strb = w_strb_d;
          wr_idx  = wr_addr[3:2];
          wr_oor  = addr_oor(wr_addr);
          if (!wr_oor) begin
            for (int b = 0; b < 4; b++) begin
              if (wr_strb[b]) regs_d[wr_idx][b*8 +: 8] = wr_data[b*8 +: 8];
            end
          end
          // Only registers 0 and 1 feed the fabric; a zero strobe changes nothing.
          ab_upd_d   = !wr_oor && !wr_idx[1] && (|wr_strb);
          bresp_d    = wr_oor ? RESP_SLVERR : RESP_OKAY;
          bvalid_d   = 1'b1;
          aw_full_d  = 1'b0;
          w_full_d   = 1'b0;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase

    // Readies are registered from the next state so they are low in WR_RESP
    // and low for any channel already holding a beat.
    awready_d = (wr_state_d == WR_IDLE) && !aw_full_d;
    wready_d  = (wr_state_d == WR_IDLE) && !w_full_d;
  end

  // Read FSM. RDATA samples regs_q, i.e. the value before this edge, so a
  // same-cycle write to the same register is not visible to this read.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    ar_hs      = s_axi.S_AXI_ARVALID & arready_q;
    rd_idx     = s_axi.S_AXI_ARADDR[3:2];
    rd_oor     = addr_oor(s_axi.S_AXI_ARADDR);

    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rdata_d    = rd_oor ? OOR_RDATA : regs_q[rd_idx];
          rresp_d    = rd_oor ? RESP_SLVERR : RESP_OKAY;
          rvalid_d   = 1'b1;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (s_axi.S_AXI_RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    arready_d = (rd_state_d == RD_IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs_q     <= {4{C_RESET_VAL}};
      wr_state_q <= WR_IDLE;
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      ab_upd_q   <= 1'b0;
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_state_q <= wr_state_d;
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      ab_upd_q   <= ab_upd_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  assign A_OUT  = regs_q[0];
  assign B_OUT  = regs_q[1];
  assign AB_UPD = ab_upd_q;

  // PROT is ignored and the byte-offset bits of the latched address are never
  // decoded; fold them here so they are visibly consumed.
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, aw_addr_q, wr_addr};

endmodule
